mov_sequencer: RTL and testbench

- Sequences MOV Rx,Ry register/memory moves through the 8:1 source mux (R0–R6 plus MEMCEE) that feeds the register file.
- Accepts move requests into a small FIFO and drives the mux select `cmsrc`.
- For memory sources, handshakes with memory before capturing the mux output.
- Issues a one-hot write enable to the destination register, or to memory for destination 7.

---
 rtl/mov_sequencer.sv | 142 ++++++++++++++
 tb/tb_mov_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mov_sequencer.sv
// rtl/mov_sequencer.sv - MOV Rx,Ry sequencer: request FIFO, source-mux select, one-hot register/memory write
// Optional feature macro: MOV_SKIP_EN (src==dst register moves retire without a write strobe).
module mov_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_src,
  input  logic [2:0] req_dst,
  output logic [2:0] cmsrc,
  input  logic [7:0] muxout,
  output logic       mem_rd,
  input  logic       mem_ack,
  output logic [7:0] wr_en,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, SELECT, MEMWAIT, CAPTURE, WRITE} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        r_state;
  logic [5:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [2:0]    r_cmsrc;
  logic [2:0]    r_dst;
  logic          r_mem_rd;
  logic [7:0]    r_wr_en;
  logic [7:0]    r_wr_data;
  logic          r_busy;
  logic          r_done;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_next;
  logic [5:0]    w_head;

  assign w_full       = (r_count == FULL);
  assign w_push       = req_valid && !w_full;
  assign w_pop        = ((r_state == IDLE) || (r_state == WRITE)) && (r_count != '0);
  assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_head       = r_mem[r_rptr];

  assign req_ready = !w_full;
  assign cmsrc     = r_cmsrc;
  assign mem_rd    = r_mem_rd;
  assign wr_en     = r_wr_en;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign done      = r_done;

  // Entry storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {req_src, req_dst};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cmsrc   <= '0;
      r_dst     <= '0;
      r_mem_rd  <= 1'b0;
      r_wr_en   <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_wr_en <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b1;
      case (r_state)
        IDLE, WRITE: begin
          if (w_pop) begin
            r_cmsrc <= w_head[5:3];
            r_dst   <= w_head[2:0];
            r_state <= SELECT;
          end else begin
            r_state <= IDLE;
            r_busy  <= (w_count_next != '0);
          end
        end
        SELECT: begin
`ifdef MOV_SKIP_EN
          if ((r_cmsrc == r_dst) && (r_cmsrc != 3'd7)) begin
            r_done  <= 1'b1;
            r_state <= WRITE;
          end else if (r_cmsrc == 3'd7) begin
            r_mem_rd <= 1'b1;
            r_state  <= MEMWAIT;
          end else begin
            r_state <= CAPTURE;
          end
`else
          if (r_cmsrc == 3'd7) begin
            r_mem_rd <= 1'b1;
            r_state  <= MEMWAIT;
          end else begin
            r_state <= CAPTURE;
          end
`endif
        end
        MEMWAIT: begin
          if (mem_ack) begin
            r_mem_rd  <= 1'b0;
            r_wr_data <= muxout;
            r_wr_en   <= 8'd1 << r_dst;
            r_done    <= 1'b1;
            r_state   <= WRITE;
          end
        end
        CAPTURE: begin
          r_wr_data <= muxout;
          r_wr_en   <= 8'd1 << r_dst;
          r_done    <= 1'b1;
          r_state   <= WRITE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mov_sequencer.sv
// tb/tb_mov_sequencer.sv - randomized bench for mov_sequencer with an in-order move-semantics reference model
module tb_mov_sequencer;

`ifdef MOV_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_src;
  logic [2:0] req_dst;
  logic [2:0] cmsrc;
  logic [7:0] muxout;
  logic       mem_rd;
  logic       mem_ack;
  logic [7:0] wr_en;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] env_regs [8];
  logic [7:0] model_regs [8];
  logic [7:0] mem_data;
  logic [7:0] mem_val;
  int         ack_delay = 0;
  bit         ack_noise = 1'b0;
  int         wait_cnt;
  logic [5:0] exp_q [$];
  logic [7:0] memq [$];

  mov_sequencer #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst),
    .cmsrc(cmsrc), .muxout(muxout),
    .mem_rd(mem_rd), .mem_ack(mem_ack),
    .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Source mux: R0-R6 from the environment register file, MEMCEE for select 7.
  assign muxout = (cmsrc == 3'd7) ? mem_data : env_regs[cmsrc];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after ack_delay MEMWAIT cycles; optional stray acks otherwise.
  initial begin
    mem_ack  = 1'b0;
    wait_cnt = 0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (rst) begin
        wait_cnt = 0;
      end else if (mem_rd) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          mem_data = mem_val;
          memq.push_back(mem_val);
          mem_val  = 8'($urandom);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (ack_noise) begin
          mem_ack  = ($urandom_range(0, 3) == 0);
          mem_data = 8'($urandom);
        end
      end
    end
  end

  // Retirement monitor: each done retires the oldest accepted move in program order.
  always @(negedge clk) begin
    logic [5:0] e;
    logic [2:0] s, d;
    logic [7:0] data;
    bit         skip;
    if (!rst && (done || wr_en != 8'd0)) begin
      chk("done_with_strobe", 32'(done), 32'd1);
      chk("wr_en_onehot", 32'($countones(wr_en) <= 1), 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        s = e[5:3];
        d = e[2:0];
        skip = SKIP && (s == d) && (s != 3'd7);
        data = 8'd0;
        if (s == 3'd7) begin
          if (memq.size() == 0) chk("mem_data_missing", 32'd0, 32'd1);
          else data = memq.pop_front();
        end else begin
          data = model_regs[s];
        end
        chk("wr_en", 32'(wr_en), skip ? 32'd0 : 32'(8'd1 << d));
        if (!skip) begin
          chk("wr_data", 32'(wr_data), 32'(data));
          if (d != 3'd7) model_regs[d] = data;
        end
        for (int n = 0; n < 7; n++) if (wr_en[n]) env_regs[n] = wr_data;
      end
    end
  end

  task automatic send(input logic [2:0] s, input logic [2:0] d);
    bit ok;
    ok = 1'b0;
    req_src   = s;
    req_dst   = d;
    req_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    else exp_q.push_back({s, d});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, held, cnt, t0;
    int dn [$];
    rst = 1'b1;
    req_valid = 1'b0;
    req_src = '0;
    req_dst = '0;
    mem_data = 8'd0;
    mem_val = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      env_regs[i]   = 8'($urandom);
      model_regs[i] = env_regs[i];
    end
    #1;
    chk("rst_cmsrc", 32'(cmsrc), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Register move: R2 -> R5, latency 3 edges after accept.
    env_regs[2] = 8'hA5;
    model_regs[2] = 8'hA5;
    send(3'd2, 3'd5);
    wait_done(lat);
    chk("reg_latency", 32'(lat), 32'd3);
    chk("reg_wr_en", 32'(wr_en), 32'h20);
    @(negedge clk);
    chk("busy_fall", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Memory source with delayed ack.
    ack_delay = 5;
    mem_val = 8'h3C;
    send(3'd7, 3'd0);
    cnt = 0;
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (mem_rd) cnt++;
      if (done) begin lat = n; break; end
    end
    chk("mem_done_seen", 32'(lat >= 0), 32'd1);
    chk("mem_rd_cycles", 32'(cnt), 32'd6);
    chk("mem_rd_at_done", 32'(mem_rd), 32'd0);
    chk("mem_wr_en", 32'(wr_en), 32'h01);
    chk("mem_wr_data", 32'(wr_data), 32'h3C);
    drain();

    // FIFO full behind a stalled memory move.
    ack_delay = 30;
    send(3'd7, 3'd1);
    for (int t = 0; t < 20 && !mem_rd; t++) @(negedge clk);
    chk("stall_mem_rd", 32'(mem_rd), 32'd1);
    @(posedge clk); #1;
    send(3'd0, 3'd1);
    send(3'd1, 3'd2);
    send(3'd2, 3'd3);
    send(3'd3, 3'd4);
    @(negedge clk);
    chk("full_ready", 32'(req_ready), 32'd0);
    req_src = 3'd4;
    req_dst = 3'd5;
    req_valid = 1'b1;
    held = 0;
    repeat (5) begin @(negedge clk); if (req_ready) held++; end
    chk("fifth_held", 32'(held), 32'd0);
    @(posedge clk); #1;
    send(3'd4, 3'd5);
    drain();

    // Back-to-back register moves: done pulses three cycles apart.
    ack_delay = 0;
    send(3'd1, 3'd6);
    send(3'd6, 3'd0);
    send(3'd4, 3'd2);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) dn.push_back(n);
    end
    chk("b2b_count", 32'(dn.size()), 32'd3);
    if (dn.size() == 3) begin
      chk("b2b_gap1", 32'(dn[1] - dn[0]), 32'd3);
      chk("b2b_gap2", 32'(dn[2] - dn[1]), 32'd3);
    end
    @(posedge clk); #1;

    // Self move R3 -> R3.
    send(3'd3, 3'd3);
    wait_done(lat);
    chk("self_latency", 32'(lat), SKIP ? 32'd2 : 32'd3);
    chk("self_wr_en", 32'(wr_en), SKIP ? 32'd0 : 32'h08);
    drain();

    // Reset during MEMWAIT with queued moves behind it.
    ack_delay = 100;
    send(3'd7, 3'd2);
    send(3'd1, 3'd3);
    send(3'd2, 3'd4);
    for (int t = 0; t < 20 && !mem_rd; t++) @(negedge clk);
    chk("pre_rst_mem_rd", 32'(mem_rd), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    memq.delete();
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    t0 = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || wr_en != 8'd0) cnt++;
      if (busy || !req_ready) t0++;
    end
    chk("post_rst_no_done", 32'(cnt), 32'd0);
    chk("post_rst_empty", 32'(t0), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic with stray acks.
    ack_noise = 1'b1;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      ack_delay = $urandom_range(0, 4);
      send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    drain();
    ack_noise = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_memq", 32'(memq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
